// File: rtl/fourbit_rr_scanner.sv
// Arbitrating front end for a 4-bit 4:1 mux: grants a channel, drives sel, captures mux_y, offers it valid/ready.
// Optional FOURBIT_RR_SCANNER_RR_FAIR_EN selects round-robin grant; otherwise fixed priority with channel 0 highest.
module fourbit_rr_scanner (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] ack,
   output logic [1:0] sel,
   input  logic [3:0] mux_y,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_data,
   output logic [1:0] out_chan
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      OUT    = 2'd2
   } state_t;

   state_t     state_q;
   logic [1:0] sel_q;
   logic [1:0] chan_q;
   logic [3:0] data_q;
   logic [3:0] ack_q;
   logic       valid_q;
   logic [1:0] grant_d;

`ifdef FOURBIT_RR_SCANNER_RR_FAIR_EN
   logic [1:0] last_q;
   logic [1:0] cand;

   // Walk from the farthest candidate to the nearest so the nearest requester after last_q wins.
   always_comb begin
      grant_d = last_q + 2'd1;
      cand    = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         cand = last_q + 2'(k + 1);
         if (req[cand]) grant_d = cand;
      end
   end
`else
   always_comb begin
      grant_d = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (req[k]) grant_d = 2'(k);
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= 2'd0;
         chan_q  <= 2'd0;
         data_q  <= 4'h0;
         ack_q   <= 4'b0000;
         valid_q <= 1'b0;
`ifdef FOURBIT_RR_SCANNER_RR_FAIR_EN
         last_q  <= 2'd3;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (|req) begin
                  sel_q   <= grant_d;
`ifdef FOURBIT_RR_SCANNER_RR_FAIR_EN
                  last_q  <= grant_d;
`endif
                  state_q <= SETTLE;
               end
            end
            // Grant is committed: capture even if the requester has dropped req.
            SETTLE: begin
               data_q  <= mux_y;
               chan_q  <= sel_q;
               valid_q <= 1'b1;
               ack_q   <= 4'b0001 << sel_q;
               state_q <= OUT;
            end
            OUT: begin
               ack_q <= 4'b0000;
               if (valid_q && out_ready) begin
                  valid_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               ack_q   <= 4'b0000;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign ack       = ack_q;
   assign sel       = sel_q;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_chan  = chan_q;

endmodule

// File: tb/tb_fourbit_rr_scanner.sv
// Bench for fourbit_rr_scanner: transaction-level model of grant order and handshake timing.
module tb_fourbit_rr_scanner;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] ack;
   logic [1:0] sel;
   logic [3:0] mux_y;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_data;
   logic [1:0] out_chan;

   logic [3:0] word [4];
   logic [1:0] m_last = 2'd3;
   int         total = 0;
   int         passed = 0;

   assign mux_y = word[sel];

   fourbit_rr_scanner dut (
      .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .sel(sel), .mux_y(mux_y),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] l);
`ifdef FOURBIT_RR_SCANNER_RR_FAIR_EN
      for (int k = 1; k <= 4; k++) begin
         int c;
         c = (int'(l) + k) % 4;
         if (r[c]) return 2'(c);
      end
`else
      for (int c = 0; c < 4; c++) if (r[c]) return 2'(c);
`endif
      return 2'd0;
   endfunction

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ack"}, {4'h0, ack}, 8'h00);
      chk({tag, "_sel"}, {6'h0, sel}, 8'h00);
      chk({tag, "_valid"}, {7'h0, out_valid}, 8'h00);
      chk({tag, "_data"}, {4'h0, out_data}, 8'h00);
      chk({tag, "_chan"}, {6'h0, out_chan}, 8'h00);
   endtask

   // One complete word: grant at E0, capture at E1, optional stall, transfer at E2.
   task automatic xfer(input logic [3:0] r, input int stall, input bit drop);
      logic [1:0] g;
      logic [3:0] w;
      g = pick(r, m_last);
      m_last = g;
      for (int c = 0; c < 4; c++) word[c] = 4'($urandom);
      w = word[g];
      req = r;
      tick();
      chk("sel_E0", {6'h0, sel}, {6'h0, g});
      chk("valid_E0", {7'h0, out_valid}, 8'h00);
      chk("ack_E0", {4'h0, ack}, 8'h00);
      if (drop) req = r & ~(4'b0001 << g);
      tick();
      chk("data_E1", {4'h0, out_data}, {4'h0, w});
      chk("chan_E1", {6'h0, out_chan}, {6'h0, g});
      chk("valid_E1", {7'h0, out_valid}, 8'h01);
      chk("ack_E1", {4'h0, ack}, {4'h0, 4'b0001 << g});
      for (int s = 0; s < stall; s++) begin
         out_ready = 1'b0;
         tick();
         chk("ack_stall", {4'h0, ack}, 8'h00);
         chk("valid_stall", {7'h0, out_valid}, 8'h01);
         chk("data_stall", {4'h0, out_data}, {4'h0, w});
         chk("chan_stall", {6'h0, out_chan}, {6'h0, g});
         chk("sel_stall", {6'h0, sel}, {6'h0, g});
      end
      out_ready = 1'b1;
      tick();
      chk("valid_E2", {7'h0, out_valid}, 8'h00);
      chk("ack_E2", {4'h0, ack}, 8'h00);
      chk("data_E2", {4'h0, out_data}, {4'h0, w});
      chk("chan_E2", {6'h0, out_chan}, {6'h0, g});
      chk("sel_E2", {6'h0, sel}, {6'h0, g});
      out_ready = 1'b0;
   endtask

   initial begin
      for (int c = 0; c < 4; c++) word[c] = 4'h0;
      repeat (2) tick();
      check_reset_vals("rst");
      rst_n = 1'b1;
      repeat (2) tick();
      check_reset_vals("post_rst_idle");

      // single request
      xfer(4'b0100, 0, 1'b0);

      // reset while a word is held in the output register
      req = 4'b0001;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      req = 4'b0000;
      tick();
      #2 rst_n = 1'b1;
      m_last = 2'd3;
      repeat (3) tick();
      check_reset_vals("rst_release");

      // fairness with all channels requesting
      for (int i = 0; i < 5; i++) xfer(4'b1111, 0, 1'b0);

      // backpressure
      xfer(4'b0011, 5, 1'b0);
      xfer(4'b0011, 0, 1'b0);

      // wrap-around
      xfer(4'b1000, 0, 1'b0);
      xfer(4'b1001, 0, 1'b0);
      xfer(4'b1001, 0, 1'b0);

      // request dropped in SETTLE
      xfer(4'b0010, 1, 1'b1);

      // randomized traffic with idle gaps
      for (int i = 0; i < 30; i++) begin
         logic [1:0] s0;
         int gap;
         gap = $urandom_range(0, 2);
         s0 = sel;
         req = 4'b0000;
         for (int k = 0; k < gap; k++) begin
            tick();
            chk("idle_sel", {6'h0, sel}, {6'h0, s0});
            chk("idle_valid", {7'h0, out_valid}, 8'h00);
         end
         xfer(4'($urandom_range(1, 15)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
